wb_queue: RTL and testbench

WB_QUEUE -- requirements
Module: wb_queue

---
 rtl/wb_queue_pkg.sv | 16 +
 rtl/wb_fwd_match.sv | 34 +++
 rtl/wb_queue.sv | 97 +++++++++
 tb/tb_wb_queue.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_queue_pkg.sv
// Shared register-file widths, zero-register address and the writeback entry layout.
// No logic; constants and types only.
// Imported by the writeback queue and its forwarding matcher.
package wb_queue_pkg;

  localparam int REG_WIDTH      = 32;
  localparam int REG_ADDR_WIDTH = 5;

  localparam logic [REG_ADDR_WIDTH-1:0] ZERO_REG = '0;

  typedef struct packed {
    logic [REG_ADDR_WIDTH-1:0] addr;
    logic [REG_WIDTH-1:0]      data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fwd_match.sv
// Finds the youngest valid queued entry whose address matches a decode read address.
// Purely combinational, zero latency.
// No flow control; the zero register never matches.
module wb_fwd_match
  import wb_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  wb_entry_t                  entries [DEPTH],
  input  logic [DEPTH-1:0]           valid,
  input  logic [PTR_W-1:0]           tail,
  input  logic [REG_ADDR_WIDTH-1:0]  addr,
  output logic                       hit,
  output logic [REG_WIDTH-1:0]       data
);

  // Walk from the oldest possible slot (tail - DEPTH) toward the newest (tail - 1);
  // later matches overwrite earlier ones, so the youngest match wins.
  always_comb begin
    logic [PTR_W-1:0] idx;
    hit  = 1'b0;
    data = '0;
    idx  = '0;
    for (int k = DEPTH; k >= 1; k--) begin
      idx = tail - PTR_W'(k);
      if ((addr != ZERO_REG) && valid[idx] && (entries[idx].addr == addr)) begin
        hit  = 1'b1;
        data = entries[idx].data;
      end
    end
  end

endmodule

// File: rtl/wb_queue.sv
// Circular writeback queue between mem stage and regfile, with youngest-entry forwarding.
// An entry enqueued at edge N drives the write port in cycle N+1 and commits at edge N+1.
// in_ready drops when full (registered count only); hold freezes draining, not filling.
module wb_queue
  import wb_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       in_we,
  input  logic [REG_ADDR_WIDTH-1:0]  in_addr,
  input  logic [REG_WIDTH-1:0]       in_data,
  input  logic                       hold,
  output logic                       write_en,
  output logic [REG_ADDR_WIDTH-1:0]  write_addr,
  output logic [REG_WIDTH-1:0]       write_data,
  input  logic [REG_ADDR_WIDTH-1:0]  fwd1_addr,
  input  logic [REG_ADDR_WIDTH-1:0]  fwd2_addr,
  output logic                       fwd1_hit,
  output logic                       fwd2_hit,
  output logic [REG_WIDTH-1:0]       fwd1_data,
  output logic [REG_WIDTH-1:0]       fwd2_data,
  output logic [PTR_W:0]             count
);

  localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);

  wb_entry_t        entries [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [DEPTH-1:0] valid;
  logic             push;
  logic             pop;
  logic             not_empty;

  // Non-writing or zero-register offers are accepted but never stored.
  assign not_empty = (count != '0);
  assign in_ready  = (count < FULL);
  assign push      = in_valid && in_ready && in_we && (in_addr != ZERO_REG);
  assign pop       = not_empty && !hold;

  assign write_en   = pop;
  assign write_addr = not_empty ? entries[head].addr : '0;
  assign write_data = not_empty ? entries[head].data : '0;

  // Slot i is live when its distance from head is below the occupancy.
  always_comb begin
    logic [PTR_W-1:0] offset;
    valid  = '0;
    offset = '0;
    for (int i = 0; i < DEPTH; i++) begin
      offset   = PTR_W'(i) - head;
      valid[i] = ({1'b0, offset} < count);
    end
  end

  // Pointer and occupancy bookkeeping; reset empties the queue immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      count <= count + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
    end
  end

  // Entry storage; validity comes from the pointers, so no reset is needed here.
  always_ff @(posedge clk) begin
    if (push) entries[tail] <= '{addr: in_addr, data: in_data};
  end

  wb_fwd_match #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_fwd1 (
    .entries (entries),
    .valid   (valid),
    .tail    (tail),
    .addr    (fwd1_addr),
    .hit     (fwd1_hit),
    .data    (fwd1_data)
  );

  wb_fwd_match #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_fwd2 (
    .entries (entries),
    .valid   (valid),
    .tail    (tail),
    .addr    (fwd2_addr),
    .hit     (fwd2_hit),
    .data    (fwd2_data)
  );

endmodule

// File: tb/tb_wb_queue.sv
// Self-checking bench for wb_queue: scoreboard of expected regfile writes plus scenario tasks.
module tb_wb_queue;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_we;
  logic [4:0]  in_addr;
  logic [31:0] in_data;
  logic        hold;
  logic        write_en;
  logic [4:0]  write_addr;
  logic [31:0] write_data;
  logic [4:0]  fwd1_addr;
  logic [4:0]  fwd2_addr;
  logic        fwd1_hit;
  logic        fwd2_hit;
  logic [31:0] fwd1_data;
  logic [31:0] fwd2_data;
  logic [2:0]  count;

  int total = 0;
  int bad   = 0;

  // Expected regfile writes, oldest first: {addr, data}
  logic [36:0] sb [$];

  wb_queue #(.DEPTH(4), .PTR_W(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_we      (in_we),
    .in_addr    (in_addr),
    .in_data    (in_data),
    .hold       (hold),
    .write_en   (write_en),
    .write_addr (write_addr),
    .write_data (write_data),
    .fwd1_addr  (fwd1_addr),
    .fwd2_addr  (fwd2_addr),
    .fwd1_hit   (fwd1_hit),
    .fwd2_hit   (fwd2_hit),
    .fwd1_data  (fwd1_data),
    .fwd2_data  (fwd2_data),
    .count      (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Every write-port commit must match the oldest outstanding expectation.
  always @(negedge clk) begin
    logic [36:0] exp_w;
    if (rst && write_en) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_write: got addr=%0d data=%h, required no write", write_addr, write_data);
      end else begin
        exp_w = sb.pop_front();
        if ({write_addr, write_data} !== exp_w) begin
          bad++;
          $display("FAIL write_order: got addr=%0d data=%h, required addr=%0d data=%h",
                   write_addr, write_data, exp_w[36:32], exp_w[31:0]);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one offer for exactly one edge; caller guarantees the queue is not full.
  task automatic offer(input logic we, input logic [4:0] addr, input logic [31:0] data);
    in_valid = 1'b1;
    in_we    = we;
    in_addr  = addr;
    in_data  = data;
    if (we && addr != 5'd0) sb.push_back({addr, data});
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_empty(input string name);
    for (int i = 0; i < 40 && count != 3'd0; i++) step();
    total++;
    if (count !== 3'd0) begin
      bad++;
      $display("FAIL %s_drain: count=%0d, required 0", name, count);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    total++;
    if ({count, in_ready, write_en, write_addr, write_data} !== {3'd0, 1'b1, 1'b0, 5'd0, 32'd0}) begin
      bad++;
      $display("FAIL reset_outputs: count=%0d rdy=%b we=%b addr=%0d data=%h, required 0 1 0 0 0",
               count, in_ready, write_en, write_addr, write_data);
    end
    total++;
    if ({fwd1_hit, fwd2_hit, fwd1_data, fwd2_data} !== {2'b00, 64'd0}) begin
      bad++;
      $display("FAIL reset_fwd: hits=%b%b d1=%h d2=%h, required 00 0 0", fwd1_hit, fwd2_hit, fwd1_data, fwd2_data);
    end
    @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic test_single();
    hold = 1'b0;
    offer(1'b1, 5'd5, 32'h1234);
    @(negedge clk);
    total++;
    if ({write_en, write_addr, write_data} !== {1'b1, 5'd5, 32'h1234}) begin
      bad++;
      $display("FAIL single_latency: we=%b addr=%0d data=%h, required 1 5 00001234", write_en, write_addr, write_data);
    end
    step();
    @(negedge clk);
    total++;
    if (count !== 3'd0) begin
      bad++;
      $display("FAIL single_count: count=%0d, required 0", count);
    end
  endtask

  task automatic test_hold_full();
    hold = 1'b1;
    for (int i = 1; i <= 4; i++) offer(1'b1, 5'(i), 32'hA0 + 32'(i));
    in_valid = 1'b1; in_we = 1'b1; in_addr = 5'd9; in_data = 32'hA5;
    sb.push_back({5'd9, 32'hA5});
    step();
    @(negedge clk);
    total++;
    if ({count, in_ready, write_en} !== {3'd4, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL full_stall: count=%0d rdy=%b we=%b, required 4 0 0", count, in_ready, write_en);
    end
    step();
    hold = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      total++;
      if ({write_en, write_addr} !== {1'b1, 5'(k)}) begin
        bad++;
        $display("FAIL release_order_%0d: we=%b addr=%0d, required 1 %0d", k, write_en, write_addr, k);
      end
      step();
      if (k == 2) in_valid = 1'b0;
    end
    wait_empty("hold_full");
  endtask

  task automatic test_fwd();
    hold = 1'b1;
    offer(1'b1, 5'd7, 32'h11);
    offer(1'b1, 5'd7, 32'h22);
    fwd1_addr = 5'd7;
    fwd2_addr = 5'd0;
    @(negedge clk);
    total++;
    if ({fwd1_hit, fwd1_data} !== {1'b1, 32'h22}) begin
      bad++;
      $display("FAIL fwd_youngest: hit=%b data=%h, required 1 00000022", fwd1_hit, fwd1_data);
    end
    total++;
    if ({fwd2_hit, fwd2_data} !== {1'b0, 32'h0}) begin
      bad++;
      $display("FAIL fwd_zero_reg: hit=%b data=%h, required 0 0", fwd2_hit, fwd2_data);
    end
    step();
    fwd2_addr = 5'd3;
    in_valid = 1'b1; in_we = 1'b1; in_addr = 5'd3; in_data = 32'h33;
    sb.push_back({5'd3, 32'h33});
    @(negedge clk);
    total++;
    if (fwd2_hit !== 1'b0) begin
      bad++;
      $display("FAIL fwd_ignores_input: hit=%b, required 0", fwd2_hit);
    end
    step();
    in_valid = 1'b0;
    @(negedge clk);
    total++;
    if ({fwd2_hit, fwd2_data, fwd1_data} !== {1'b1, 32'h33, 32'h22}) begin
      bad++;
      $display("FAIL fwd_after_enq: hit=%b d2=%h d1=%h, required 1 00000033 00000022", fwd2_hit, fwd2_data, fwd1_data);
    end
    step();
    hold = 1'b0;
    fwd1_addr = 5'd0;
    fwd2_addr = 5'd0;
    wait_empty("fwd");
  endtask

  task automatic test_drop();
    hold = 1'b0;
    offer(1'b0, 5'd6, 32'hDEAD);
    offer(1'b1, 5'd0, 32'hBEEF);
    @(negedge clk);
    total++;
    if ({count, write_en, in_ready} !== {3'd0, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL drop_offer: count=%0d we=%b rdy=%b, required 0 0 1", count, write_en, in_ready);
    end
    step();
  endtask

  task automatic test_back_to_back();
    hold = 1'b1;
    offer(1'b1, 5'd10, 32'hB0);
    offer(1'b1, 5'd11, 32'hB1);
    hold = 1'b0;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; in_we = 1'b1;
      in_addr  = 5'(1 + (i % 31));
      in_data  = $urandom;
      sb.push_back({in_addr, in_data});
      @(negedge clk);
      total++;
      if ({count, write_en} !== {3'd2, 1'b1}) begin
        bad++;
        $display("FAIL b2b_count_%0d: count=%0d we=%b, required 2 1", i, count, write_en);
      end
      step();
    end
    in_valid = 1'b0;
    wait_empty("b2b");
  endtask

  task automatic test_reset_mid();
    hold = 1'b1;
    for (int i = 0; i < 3; i++) offer(1'b1, 5'(20 + i), 32'hC0 + 32'(i));
    hold = 1'b0;
    #2 rst = 1'b0;
    sb.delete();
    #1;
    total++;
    if ({count, write_en, in_ready, write_addr} !== {3'd0, 1'b0, 1'b1, 5'd0}) begin
      bad++;
      $display("FAIL async_reset: count=%0d we=%b rdy=%b addr=%0d, required 0 0 1 0", count, write_en, in_ready, write_addr);
    end
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (4) step();
    total++;
    if ({count, write_en, fwd1_hit} !== {3'd0, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL reset_no_stale: count=%0d we=%b hit=%b, required 0 0 0", count, write_en, fwd1_hit);
    end
    offer(1'b1, 5'd30, 32'h77);
    wait_empty("post_reset");
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; in_we = 1'b0; in_addr = '0; in_data = '0;
    hold = 1'b0; fwd1_addr = '0; fwd2_addr = '0;
    test_reset();
    test_single();
    test_hold_full();
    test_fwd();
    test_drop();
    test_back_to_back();
    test_reset_mid();
    repeat (2) step();
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_leftover: pending=%0d, required 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
